eth_dma_desc_sched: RTL and testbench
=====================================

Name: eth_dma_desc_sched

Overview:
- Per-channel DMA descriptor scheduler between the MAC control-register block and one DMA engine. One instance serves RX and one serves TX.
- Buffers descriptors written by software in a FIFO and issues them to the DMA engine with a valid/ready handshake.
- Limits the number of in-flight descriptors, consumes DMA completion status, and generates done/error interrupt pulses and completion counters.

Parameters:
- DESC_DEPTH, 8: descriptor FIFO depth. Must be a power of 2, minimum 2.
- MAX_OUTSTANDING, 4: maximum descriptors issued but not yet completed. Range 1..15.
- ADDR_WIDTH, 32: descriptor address width.
- LEN_WIDTH, 20: descriptor length width.
- TAG_WIDTH, 8: descriptor tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  issue enable (ctrl dma_rx_enable / dma_tx_enable).
- flush  in  1  level; discard all queued, un-issued descriptors.
- s_desc_addr  in  ADDR_WIDTH  descriptor address from the register block.
- s_desc_len  in  LEN_WIDTH  descriptor length.
- s_desc_tag  in  TAG_WIDTH  descriptor tag.
- s_desc_valid  in  1  descriptor push valid.
- s_desc_ready  out  1  FIFO can accept.
- m_desc_addr  out  ADDR_WIDTH  descriptor address to the DMA engine.
- m_desc_len  out  LEN_WIDTH  descriptor length to DMA.
- m_desc_tag  out  TAG_WIDTH  descriptor tag to DMA.
- m_desc_valid  out  1  descriptor valid to DMA.
- m_desc_ready  in  1  DMA accepts descriptor.
- s_status_tag  in  TAG_WIDTH  completion tag.
- s_status_error  in  4  completion error code; 0 means OK.
- s_status_valid  in  1  completion strobe. No ready: always accepted.
- irq_done  out  1  one-cycle pulse per good completion.
- irq_error  out  1  one-cycle pulse per error event.
- fifo_count  out  $clog2(DESC_DEPTH)+1  queued descriptors.
- outstanding_count  out  4  issued, uncompleted descriptors.
- done_count  out  16  good completions, saturating.
- last_status_tag  out  TAG_WIDTH  tag of the most recent accepted status.

Behaviour:
- Reset (async, rst high):
  - FIFO empty; state IDLE.
  - All outputs 0, except s_desc_ready = 1 after reset when flush = 0.
- Push rules:
  - s_desc_ready = !full && state != FLUSH.
  - A push occurs when s_desc_valid && s_desc_ready; the FIFO write is registered.
  - Push and pop in the same cycle leave fifo_count unchanged.
- FSM states: IDLE, ISSUE, FLUSH.
  - IDLE → FLUSH: flush = 1. Flush has priority over issue.
  - IDLE → pop: when enable && fifo_count > 0 && outstanding_count < MAX_OUTSTANDING, pop the FIFO head into the m_desc_* registers.
    - If popped len == 0: drop it, pulse irq_error, stay IDLE.
    - Otherwise: go to ISSUE.
  - ISSUE: m_desc_valid = 1 with m_desc_* stable until m_desc_ready.
    - On handshake: m_desc_valid → 0, outstanding_count += 1, go to IDLE.
    - flush and enable are ignored while in ISSUE; valid never drops before the handshake.
  - FLUSH: FIFO pointers reset (fifo_count = 0) on entry. Stay while flush = 1, then return to IDLE.
    - outstanding_count is unaffected, and completions are still processed.
- Issue throughput: at most one descriptor per 2 cycles. Issue-to-valid latency is 1 cycle after the pop condition.
- Status handling (every cycle s_status_valid = 1):
  - last_status_tag <= s_status_tag.
  - If outstanding_count == 0: spurious status. Pulse irq_error; no count changes.
  - Else outstanding_count -= 1, then:
    - If s_status_error != 0: pulse irq_error.
    - Else: pulse irq_done and increment done_count, saturating at 16'hFFFF.
- Simultaneous issue handshake and status: outstanding_count changes by net 0.
- Simultaneous zero-length drop and error status: irq_error is a single pulse. Bench must not count pulses as events in this case.
- enable low: blocks new pops only. An issue in progress completes.
- Reset mid-ISSUE: m_desc_valid drops immediately (async). Accepted as the reset exception to the handshake rule.

Test Plan:
- Push 3 descriptors (addr 0x1000/0x2000/0x3000, len 64, tags 1/2/3) with enable = 1 and m_desc_ready = 1 → 3 DMA handshakes in order, valid high 1 cycle each, ≥1 idle cycle between; outstanding_count = 3.
- MAX_OUTSTANDING = 4; push 6 descriptors, no status → exactly 4 issued, fifo_count = 2. One OK status (tag 1) → irq_done pulse, 5th issued, done_count = 1.
- Fill the FIFO to 8 with enable = 0 → s_desc_ready = 0, 9th push stalls. Assert flush 1 cycle → fifo_count = 0, s_desc_ready = 1, no issue occurs.
- Status with error = 4'h2 while outstanding = 1 → irq_error pulse, outstanding = 0, done_count unchanged, last_status_tag updated. Second status with outstanding = 0 → irq_error pulse (spurious).
- Hold m_desc_ready = 0 for 5 cycles, toggle flush and enable meanwhile → m_desc_* stable and valid held; after handshake, flush is applied.
- Issue handshake and OK status in the same cycle → outstanding_count unchanged. Set done_count to 0xFFFF via 65535 completions (or force) → stays at 0xFFFF.

Source files
------------

// File: rtl/eth_dma_desc_sched.sv
// Per-channel DMA descriptor scheduler: queues software descriptors, issues them to one DMA
// engine under an in-flight limit, and turns completion status into irq pulses and counters.
module eth_dma_desc_sched #(
    parameter int DESC_DEPTH      = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int LEN_WIDTH       = 20,
    parameter int TAG_WIDTH       = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          flush,
    input  logic [ADDR_WIDTH-1:0]         s_desc_addr,
    input  logic [LEN_WIDTH-1:0]          s_desc_len,
    input  logic [TAG_WIDTH-1:0]          s_desc_tag,
    input  logic                          s_desc_valid,
    output logic                          s_desc_ready,
    output logic [ADDR_WIDTH-1:0]         m_desc_addr,
    output logic [LEN_WIDTH-1:0]          m_desc_len,
    output logic [TAG_WIDTH-1:0]          m_desc_tag,
    output logic                          m_desc_valid,
    input  logic                          m_desc_ready,
    input  logic [TAG_WIDTH-1:0]          s_status_tag,
    input  logic [3:0]                    s_status_error,
    input  logic                          s_status_valid,
    output logic                          irq_done,
    output logic                          irq_error,
    output logic [$clog2(DESC_DEPTH):0]   fifo_count,
    output logic [3:0]                    outstanding_count,
    output logic [15:0]                   done_count,
    output logic [TAG_WIDTH-1:0]          last_status_tag
);

    localparam int PW = $clog2(DESC_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DESC_DEPTH);
    localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_e;

    state_e state_q, state_d;
    logic [PW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic [LEN_WIDTH-1:0] m_len_q, m_len_d;
    logic [TAG_WIDTH-1:0] m_tag_q, m_tag_d;
    logic m_valid_q, m_valid_d;
    logic [3:0] outstanding_q, outstanding_d;
    logic irq_done_q, irq_done_d, irq_error_q, irq_error_d;
    logic [15:0] done_count_q, done_count_d;
    logic [TAG_WIDTH-1:0] last_tag_q, last_tag_d;

    logic [ADDR_WIDTH-1:0] addr_mem [DESC_DEPTH];
    logic [LEN_WIDTH-1:0]  len_mem  [DESC_DEPTH];
    logic [TAG_WIDTH-1:0]  tag_mem  [DESC_DEPTH];

    logic [PW:0] count;
    logic full, push, pop, drop, handshake, clear, status_ok;

    assign count        = wr_ptr_q - rd_ptr_q;
    assign full         = (count == DEPTH_C);
    assign s_desc_ready = !full && (state_q != FLUSH);
    assign push         = s_desc_valid && s_desc_ready;

    // Descriptor storage has no reset; only the pointers define what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q[PW-1:0]] <= s_desc_addr;
            len_mem[wr_ptr_q[PW-1:0]]  <= s_desc_len;
            tag_mem[wr_ptr_q[PW-1:0]]  <= s_desc_tag;
        end
    end

    always_comb begin
        state_d   = state_q;
        m_addr_d  = m_addr_q;
        m_len_d   = m_len_q;
        m_tag_d   = m_tag_q;
        pop       = 1'b0;
        drop      = 1'b0;
        handshake = 1'b0;
        clear     = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = FLUSH;
                    clear   = 1'b1;
                end else if (enable && (count != '0) && (outstanding_q < MAX_OUT_C)) begin
                    pop      = 1'b1;
                    m_addr_d = addr_mem[rd_ptr_q[PW-1:0]];
                    m_len_d  = len_mem[rd_ptr_q[PW-1:0]];
                    m_tag_d  = tag_mem[rd_ptr_q[PW-1:0]];
                    if (len_mem[rd_ptr_q[PW-1:0]] == '0) begin
                        drop = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (m_desc_ready) begin
                    handshake = 1'b1;
                    state_d   = IDLE;
                end
            end
            FLUSH: begin
                clear = 1'b1;
                if (!flush) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        m_valid_d = (state_d == ISSUE);
    end

    // A push accepted on the flush-entry cycle is discarded along with the rest of the queue.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_comb begin
        status_ok     = s_status_valid && (outstanding_q != 4'd0);
        outstanding_d = outstanding_q + {3'b000, handshake} - {3'b000, status_ok};
        irq_done_d    = status_ok && (s_status_error == 4'h0);
        irq_error_d   = drop || (s_status_valid && ((outstanding_q == 4'd0) || (s_status_error != 4'h0)));
        done_count_d  = done_count_q;
        if (irq_done_d && (done_count_q != 16'hFFFF)) begin
            done_count_d = done_count_q + 16'd1;
        end
        last_tag_d = s_status_valid ? s_status_tag : last_tag_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            m_addr_q      <= '0;
            m_len_q       <= '0;
            m_tag_q       <= '0;
            m_valid_q     <= 1'b0;
            outstanding_q <= 4'd0;
            irq_done_q    <= 1'b0;
            irq_error_q   <= 1'b0;
            done_count_q  <= 16'd0;
            last_tag_q    <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            m_addr_q      <= m_addr_d;
            m_len_q       <= m_len_d;
            m_tag_q       <= m_tag_d;
            m_valid_q     <= m_valid_d;
            outstanding_q <= outstanding_d;
            irq_done_q    <= irq_done_d;
            irq_error_q   <= irq_error_d;
            done_count_q  <= done_count_d;
            last_tag_q    <= last_tag_d;
        end
    end

    assign m_desc_addr       = m_addr_q;
    assign m_desc_len        = m_len_q;
    assign m_desc_tag        = m_tag_q;
    assign m_desc_valid      = m_valid_q;
    assign irq_done          = irq_done_q;
    assign irq_error         = irq_error_q;
    assign fifo_count        = count;
    assign outstanding_count = outstanding_q;
    assign done_count        = done_count_q;
    assign last_status_tag   = last_tag_q;

endmodule

// File: tb/tb_eth_dma_desc_sched.sv
// Testbench for eth_dma_desc_sched: directed scenarios plus randomized traffic, all checked
// every cycle against a queue-based descriptor/completion model.
module tb_eth_dma_desc_sched;

   localparam int DEPTH  = 8;
   localparam int MAXOUT = 4;

   typedef struct {
      logic [31:0] addr;
      logic [19:0] len;
      logic [7:0]  tag;
   } desc_t;

   logic clock = 1'b0;
   logic reset;
   logic enable, flush;
   logic [31:0] sDescAddr;
   logic [19:0] sDescLen;
   logic [7:0] sDescTag;
   logic sDescValid, sDescReady;
   logic [31:0] mDescAddr;
   logic [19:0] mDescLen;
   logic [7:0] mDescTag;
   logic mDescValid, mDescReady;
   logic [7:0] sStatusTag;
   logic [3:0] sStatusError;
   logic sStatusValid;
   logic irqDone, irqError;
   logic [3:0] fifoCount;
   logic [3:0] outstandingCount;
   logic [15:0] doneCount;
   logic [7:0] lastStatusTag;

   int testsRun = 0;
   int testsFailed = 0;

   // Reference model state: queued descriptors, the one held for the DMA, and completion bookkeeping
   desc_t fifoQ[$];
   desc_t pend;
   bit pendValid, flushing, expDone, expErr;
   int outstanding, doneCnt;
   logic [7:0] expLastTag;

   eth_dma_desc_sched #(
      .DESC_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXOUT),
      .ADDR_WIDTH(32), .LEN_WIDTH(20), .TAG_WIDTH(8)
   ) dut (
      .clk(clock), .rst(reset), .enable(enable), .flush(flush),
      .s_desc_addr(sDescAddr), .s_desc_len(sDescLen), .s_desc_tag(sDescTag),
      .s_desc_valid(sDescValid), .s_desc_ready(sDescReady),
      .m_desc_addr(mDescAddr), .m_desc_len(mDescLen), .m_desc_tag(mDescTag),
      .m_desc_valid(mDescValid), .m_desc_ready(mDescReady),
      .s_status_tag(sStatusTag), .s_status_error(sStatusError), .s_status_valid(sStatusValid),
      .irq_done(irqDone), .irq_error(irqError), .fifo_count(fifoCount),
      .outstanding_count(outstandingCount), .done_count(doneCount),
      .last_status_tag(lastStatusTag)
   );

   // Free-running 10-unit clock
   always #5 clock = ~clock;

   // Single point of comparison: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drives every DUT input for the coming cycle
   task automatic applyStimulus(input bit en, input bit fl, input bit sv, input logic [31:0] addr,
                                input logic [19:0] len, input logic [7:0] tag, input bit mr,
                                input bit stv, input logic [7:0] stTag, input logic [3:0] stErr);
      enable = en; flush = fl; sDescValid = sv; sDescAddr = addr; sDescLen = len; sDescTag = tag;
      mDescReady = mr; sStatusValid = stv; sStatusTag = stTag; sStatusError = stErr;
   endtask

   task automatic idleStim(input bit mr);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 20'h0, 8'h0, mr, 1'b0, 8'h0, 4'h0);
   endtask

   task automatic modelReset();
      fifoQ.delete();
      pendValid = 0; flushing = 0; expDone = 0; expErr = 0;
      outstanding = 0; doneCnt = 0; expLastTag = 8'h0;
   endtask

   // Compares all observable outputs with the model's view of the current cycle
   task automatic compareAll();
      checkOutput("s_desc_ready", 32'(sDescReady), 32'((fifoQ.size() < DEPTH) && !flushing));
      checkOutput("m_desc_valid", 32'(mDescValid), 32'(pendValid));
      if (pendValid && mDescValid) begin
         checkOutput("m_desc_addr", mDescAddr, pend.addr);
         checkOutput("m_desc_len", 32'(mDescLen), 32'(pend.len));
         checkOutput("m_desc_tag", 32'(mDescTag), 32'(pend.tag));
      end
      checkOutput("fifo_count", 32'(fifoCount), 32'(fifoQ.size()));
      checkOutput("outstanding_count", 32'(outstandingCount), 32'(outstanding));
      checkOutput("irq_done", 32'(irqDone), 32'(expDone));
      checkOutput("irq_error", 32'(irqError), 32'(expErr));
      checkOutput("done_count", 32'(doneCount), 32'(doneCnt));
      checkOutput("last_status_tag", 32'(lastStatusTag), 32'(expLastTag));
   endtask

   // Advances the model by one clock using the inputs that were present at the edge
   task automatic modelStep();
      bit readyNow, hs, dec, nextErr, nextDone, dropPush;
      desc_t d;
      readyNow = (fifoQ.size() < DEPTH) && !flushing;
      hs = pendValid && mDescReady;
      dec = 0; nextErr = 0; nextDone = 0; dropPush = 0;
      if (sStatusValid) begin
         expLastTag = sStatusTag;
         if (outstanding == 0) nextErr = 1;
         else begin
            dec = 1;
            if (sStatusError != 4'h0) nextErr = 1;
            else begin
               nextDone = 1;
               if (doneCnt < 65535) doneCnt++;
            end
         end
      end
      if (pendValid) begin
         if (hs) pendValid = 0;
      end else if (flushing) begin
         flushing = flush;
      end else if (flush) begin
         flushing = 1;
         fifoQ.delete();
         dropPush = 1;
      end else if (enable && fifoQ.size() > 0 && outstanding < MAXOUT) begin
         d = fifoQ.pop_front();
         if (d.len == 20'h0) nextErr = 1;
         else begin
            pend = d;
            pendValid = 1;
         end
      end
      if (sDescValid && readyNow && !dropPush) begin
         d.addr = sDescAddr; d.len = sDescLen; d.tag = sDescTag;
         fifoQ.push_back(d);
      end
      outstanding = outstanding + int'(hs) - int'(dec);
      expDone = nextDone;
      expErr = nextErr;
   endtask

   // One cycle: check mid-low-phase, clock the DUT and model together, return to the falling edge
   task automatic runCycle();
      #1;
      compareAll();
      @(posedge clock);
      modelStep();
      @(negedge clock);
   endtask

   task automatic doReset();
      @(negedge clock);
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 20'h0, 8'h0, 1'b0, 1'b0, 8'h0, 4'h0);
      modelReset();
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic pushDesc(input bit en, input bit mr, input logic [31:0] addr,
                           input logic [19:0] len, input logic [7:0] tag);
      applyStimulus(en, 1'b0, 1'b1, addr, len, tag, mr, 1'b0, 8'h0, 4'h0);
      runCycle();
   endtask

   task automatic statusCycle(input bit mr, input logic [7:0] stTag, input logic [3:0] stErr);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 20'h0, 8'h0, mr, 1'b1, stTag, stErr);
      runCycle();
   endtask

   task automatic idleCycles(input int n, input bit mr);
      for (int i = 0; i < n; i++) begin
         idleStim(mr);
         runCycle();
      end
   endtask

   // Bounded wait for the model to hold a descriptor at the DMA interface
   task automatic waitPending(input int budget, input bit mr);
      int left;
      left = budget;
      while (!pendValid && left > 0) begin
         idleStim(mr);
         runCycle();
         left--;
      end
      checkOutput("waitPending_timeout", 32'(pendValid), 32'd1);
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 20'h0, 8'h0, 1'b0, 1'b0, 8'h0, 4'h0);
      modelReset();

      // Reset state: everything zero, ready high
      doReset();
      #1;
      checkOutput("rst_s_desc_ready", 32'(sDescReady), 32'd1);
      checkOutput("rst_m_desc_valid", 32'(mDescValid), 32'd0);
      checkOutput("rst_fifo_count", 32'(fifoCount), 32'd0);
      checkOutput("rst_outstanding", 32'(outstandingCount), 32'd0);
      checkOutput("rst_done_count", 32'(doneCount), 32'd0);
      checkOutput("rst_irqs", {30'd0, irqDone, irqError}, 32'd0);
      @(negedge clock);

      // Three descriptors issued back to back in order
      pushDesc(1'b1, 1'b1, 32'h1000, 20'd64, 8'd1);
      pushDesc(1'b1, 1'b1, 32'h2000, 20'd64, 8'd2);
      pushDesc(1'b1, 1'b1, 32'h3000, 20'd64, 8'd3);
      idleCycles(8, 1'b1);
      checkOutput("three_outstanding", 32'(outstandingCount), 32'd3);

      // In-flight limit: six pushed, four issued, then one completion frees a slot
      doReset();
      for (int i = 0; i < 6; i++) pushDesc(1'b1, 1'b1, 32'h100 * (i + 1), 20'd128, 8'(i + 1));
      idleCycles(10, 1'b1);
      checkOutput("limit_fifo_count", 32'(fifoCount), 32'd2);
      checkOutput("limit_outstanding", 32'(outstandingCount), 32'd4);
      statusCycle(1'b1, 8'd1, 4'h0);
      idleCycles(4, 1'b1);
      checkOutput("limit_done_count", 32'(doneCount), 32'd1);
      checkOutput("limit_fifo_after", 32'(fifoCount), 32'd1);

      // Fill with issue disabled, stall the ninth push, then flush for one cycle
      doReset();
      for (int i = 0; i < 9; i++) pushDesc(1'b0, 1'b1, 32'hA000 + 32'(i), 20'd32, 8'(i));
      checkOutput("full_ready_low", 32'(sDescReady), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 20'h0, 8'h0, 1'b1, 1'b0, 8'h0, 4'h0);
      runCycle();
      idleCycles(4, 1'b1);
      checkOutput("flush_outstanding", 32'(outstandingCount), 32'd0);

      // Error completion, then a spurious one, plus a zero-length drop
      doReset();
      pushDesc(1'b1, 1'b1, 32'h4000, 20'd10, 8'h11);
      idleCycles(3, 1'b1);
      statusCycle(1'b1, 8'h55, 4'h2);
      idleCycles(1, 1'b1);
      statusCycle(1'b1, 8'h66, 4'h0);
      pushDesc(1'b1, 1'b1, 32'h5000, 20'd0, 8'h12);
      idleCycles(3, 1'b1);

      // DMA stalls while flush and enable toggle; flush takes effect after the handshake
      doReset();
      pushDesc(1'b1, 1'b0, 32'h6000, 20'd99, 8'h21);
      pushDesc(1'b1, 1'b0, 32'h7000, 20'd98, 8'h22);
      waitPending(4, 1'b0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(i[0], ~i[0], 1'b0, 32'h0, 20'h0, 8'h0, 1'b0, 1'b0, 8'h0, 4'h0);
         runCycle();
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 20'h0, 8'h0, 1'b1, 1'b0, 8'h0, 4'h0);
      runCycle();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 20'h0, 8'h0, 1'b1, 1'b0, 8'h0, 4'h0);
      runCycle();
      idleCycles(3, 1'b1);
      checkOutput("stall_flushed", 32'(fifoCount), 32'd0);

      // Simultaneous handshake and completion, then done_count saturation
      doReset();
      force dut.done_count_q = 16'hFFFE;
      #1;
      release dut.done_count_q;
      doneCnt = 65534;
      pushDesc(1'b1, 1'b1, 32'h8000, 20'd1, 8'h31);
      idleCycles(3, 1'b1);
      pushDesc(1'b1, 1'b0, 32'h9000, 20'd2, 8'h32);
      waitPending(4, 1'b0);
      statusCycle(1'b1, 8'h31, 4'h0);
      checkOutput("net_zero_outstanding", 32'(outstandingCount), 32'd1);
      statusCycle(1'b1, 8'h32, 4'h0);
      idleCycles(2, 1'b1);
      checkOutput("saturated", 32'(doneCount), 32'hFFFF);

      // Randomized traffic with phase-dependent biases
      doReset();
      for (int phase = 0; phase < 4; phase++) begin
         for (int c = 0; c < 400; c++) begin
            applyStimulus(
               $urandom_range(0, 9) < ((phase == 2) ? 5 : 9),
               $urandom_range(0, 29) == 0,
               $urandom_range(0, 1) == 1,
               $urandom(),
               ($urandom_range(0, 7) == 0) ? 20'd0 : 20'($urandom_range(1, 1500)),
               8'($urandom()),
               (phase == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
               $urandom_range(0, (phase == 3) ? 1 : 3) == 0,
               8'($urandom()),
               ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'h0);
            runCycle();
         end
      end

      // Asynchronous reset while a descriptor is being offered drops valid at once
      doReset();
      pushDesc(1'b1, 1'b0, 32'hB000, 20'd5, 8'h41);
      waitPending(4, 1'b0);
      #1;
      checkOutput("pre_reset_valid", 32'(mDescValid), 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("async_reset_valid", 32'(mDescValid), 32'd0);
      modelReset();
      @(negedge clock);
      reset = 1'b0;
      idleCycles(2, 1'b1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
